// File: rtl/mmu_controller.sv
// Sequencer for one 2x2 systolic matrix multiply: byte-serial operand load,
// accumulator clear, three skewed feed cycles, drain, snapshot and result streaming.
module mmu_controller #(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned ACC_W        = 16,
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load_valid,
  output logic                load_ready,
  input  logic [DATA_W-1:0]   load_data,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                feed_en,
  output logic [1:0]          feed_cycle,
  output logic                mmu_clear,
  output logic [4*DATA_W-1:0] weights,
  output logic [4*DATA_W-1:0] inputs,
  input  logic [4*ACC_W-1:0]  acc_in,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [ACC_W-1:0]    res_data,
  output logic [1:0]          res_idx
);

  typedef enum logic [2:0] {
    IDLE, LOAD, ARMED, CLEAR, FEED, DRAIN, CAPTURE, OUT
  } state_t;

  localparam logic [2:0] DRAIN_LAST = (DRAIN_CYCLES == 0) ? 3'd0 : 3'(DRAIN_CYCLES - 1);

  state_t            state, state_n;
  logic [2:0]        byte_cnt, byte_cnt_n;
  logic [2:0]        cyc_cnt, cyc_cnt_n;
  logic [1:0]        res_idx_n;
  logic [ACC_W-1:0]  res_data_n;
  logic              byte_we, done_n;
  logic [DATA_W-1:0] opnd [8];
  logic [ACC_W-1:0]  snap [4];

  wire load_fire = load_valid && load_ready;
  wire res_fire  = res_valid && res_ready;

  assign weights = {opnd[3], opnd[2], opnd[1], opnd[0]};
  assign inputs  = {opnd[7], opnd[6], opnd[5], opnd[4]};

  always_comb begin
    state_n    = state;
    byte_cnt_n = byte_cnt;
    cyc_cnt_n  = cyc_cnt;
    res_idx_n  = res_idx;
    res_data_n = res_data;
    byte_we    = 1'b0;
    done_n     = 1'b0;
    case (state)
      IDLE: if (load_fire) begin
        byte_we    = 1'b1;
        byte_cnt_n = 3'd1;
        state_n    = LOAD;
      end
      LOAD: if (load_fire) begin
        byte_we    = 1'b1;
        byte_cnt_n = byte_cnt + 3'd1;
        if (byte_cnt == 3'd7) state_n = ARMED;
      end
      ARMED: if (start) state_n = CLEAR;
      CLEAR: begin
        state_n   = FEED;
        cyc_cnt_n = '0;
      end
      FEED: begin
        if (cyc_cnt == 3'd2) begin
          cyc_cnt_n = '0;
          state_n   = (DRAIN_CYCLES == 0) ? CAPTURE : DRAIN;
        end else begin
          cyc_cnt_n = cyc_cnt + 3'd1;
        end
      end
      DRAIN: begin
        if (cyc_cnt == DRAIN_LAST) begin
          cyc_cnt_n = '0;
          state_n   = CAPTURE;
        end else begin
          cyc_cnt_n = cyc_cnt + 3'd1;
        end
      end
      CAPTURE: begin
        state_n    = OUT;
        res_idx_n  = '0;
        // First word bypasses the snapshot so it is valid in the first OUT cycle.
        res_data_n = acc_in[ACC_W-1:0];
      end
      OUT: begin
        if (res_fire) begin
          res_idx_n = res_idx + 2'd1;
          if (res_idx == 2'd3) begin
            state_n    = IDLE;
            done_n     = 1'b1;
            res_data_n = '0;
          end else begin
            res_data_n = snap[res_idx + 2'd1];
          end
        end else begin
          res_data_n = snap[res_idx];
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from the next-state decode so they line up with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      byte_cnt   <= '0;
      cyc_cnt    <= '0;
      load_ready <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      feed_en    <= 1'b0;
      feed_cycle <= '0;
      mmu_clear  <= 1'b0;
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_idx    <= '0;
      for (int unsigned i = 0; i < 8; i++) opnd[i] <= '0;
      for (int unsigned i = 0; i < 4; i++) snap[i] <= '0;
    end else begin
      state      <= state_n;
      byte_cnt   <= byte_cnt_n;
      cyc_cnt    <= cyc_cnt_n;
      load_ready <= (state_n == IDLE) || (state_n == LOAD);
      busy       <= !((state_n == IDLE) || (state_n == ARMED));
      done       <= done_n;
      feed_en    <= (state_n == FEED);
      feed_cycle <= (state_n == FEED) ? cyc_cnt_n[1:0] : 2'd0;
      mmu_clear  <= (state_n == CLEAR);
      res_valid  <= (state_n == OUT);
      res_data   <= res_data_n;
      res_idx    <= res_idx_n;
      if (byte_we) opnd[(state == IDLE) ? 3'd0 : byte_cnt] <= load_data;
      if (state == CAPTURE)
        for (int unsigned i = 0; i < 4; i++) snap[i] <= acc_in[i*ACC_W +: ACC_W];
    end
  end

endmodule

// File: tb/tb_mmu_controller.sv
// Bench for mmu_controller: a DRAIN_CYCLES=2 and a DRAIN_CYCLES=0 instance, each
// driving a behavioural 2x2 array with matching drain latency.
module tb_mmu_controller;

  typedef struct packed {
    logic [7:0][7:0]  b;   // b[0..3]=w0..w3, b[4..7]=i0..i3
    logic [3:0][15:0] c;   // c[0]=c00, c[1]=c01, c[2]=c10, c[3]=c11
  } vec_t;

  typedef struct packed {
    logic [1:0]  idx;
    logic [15:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        load_valid [2];
  logic        load_ready [2];
  logic [7:0]  load_data  [2];
  logic        start      [2];
  logic        busy       [2];
  logic        done       [2];
  logic        feed_en    [2];
  logic [1:0]  feed_cycle [2];
  logic        mmu_clear  [2];
  logic [31:0] weights    [2];
  logic [31:0] inputs     [2];
  logic [63:0] acc_in     [2];
  logic        res_valid  [2];
  logic        res_ready  [2];
  logic [15:0] res_data   [2];
  logic [1:0]  res_idx    [2];

  mmu_controller #(.DATA_W(8), .ACC_W(16), .DRAIN_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid[0]), .load_ready(load_ready[0]),
    .load_data(load_data[0]), .start(start[0]), .busy(busy[0]), .done(done[0]),
    .feed_en(feed_en[0]), .feed_cycle(feed_cycle[0]), .mmu_clear(mmu_clear[0]),
    .weights(weights[0]), .inputs(inputs[0]), .acc_in(acc_in[0]), .res_valid(res_valid[0]),
    .res_ready(res_ready[0]), .res_data(res_data[0]), .res_idx(res_idx[0]));

  mmu_controller #(.DATA_W(8), .ACC_W(16), .DRAIN_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid[1]), .load_ready(load_ready[1]),
    .load_data(load_data[1]), .start(start[1]), .busy(busy[1]), .done(done[1]),
    .feed_en(feed_en[1]), .feed_cycle(feed_cycle[1]), .mmu_clear(mmu_clear[1]),
    .weights(weights[1]), .inputs(inputs[1]), .acc_in(acc_in[1]), .res_valid(res_valid[1]),
    .res_ready(res_ready[1]), .res_data(res_data[1]), .res_idx(res_idx[1]));

  // Array model: products land on feed cycles 1 and 2; instance 0 sees a 2-cycle drain pipe.
  logic [15:0] am [2][4];
  logic [15:0] p1 [4];
  logic [15:0] p2 [4];
  int s;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) for (int k = 0; k < 4; k++) am[d][k] <= '0;
      for (int k = 0; k < 4; k++) begin p1[k] <= '0; p2[k] <= '0; end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (mmu_clear[d]) begin
          for (int k = 0; k < 4; k++) am[d][k] <= '0;
        end else if (feed_en[d] && feed_cycle[d] != 2'd0) begin
          s = int'(feed_cycle[d]) - 1;
          for (int r = 0; r < 2; r++) for (int c = 0; c < 2; c++)
            am[d][r*2+c] <= am[d][r*2+c] +
              16'(int'(weights[d][8*(r+2*s) +: 8]) * int'(inputs[d][8*(2*c+s) +: 8]));
        end
      end
      for (int k = 0; k < 4; k++) begin p1[k] <= am[0][k]; p2[k] <= p1[k]; end
    end
  end

  always_comb begin
    acc_in[0] = {p2[3], p2[2], p2[1], p2[0]};
    acc_in[1] = {am[1][3], am[1][2], am[1][1], am[1][0]};
  end

  int   checks = 0;
  int   bad = 0;
  exp_t q0[$];
  exp_t q1[$];
  bit   pend [2];
  vec_t tbl [5];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push(input int d, input logic [1:0] idx, input logic [15:0] data);
    exp_t e;
    e.idx = idx;
    e.data = data;
    if (d == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  function automatic bit pop(input int d, output exp_t e);
    e = '0;
    if (d == 0) begin
      if (q0.size() == 0) return 1'b0;
      e = q0.pop_front();
    end else begin
      if (q1.size() == 0) return 1'b0;
      e = q1.pop_front();
    end
    return 1'b1;
  endfunction

  // Scoreboard: compare each result handshake and the done pulse that must follow idx 3.
  always begin
    exp_t e;
    @(negedge clk);
    #2;
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        pend[d] = 1'b0;
      end else begin
        check($sformatf("done_pulse%0d", d), 64'(done[d]), 64'(pend[d]));
        pend[d] = 1'b0;
        if (res_valid[d] && res_ready[d]) begin
          if (!pop(d, e)) begin
            checks++;
            bad++;
            $display("FAIL unexpected_result%0d: got idx %0d data %0d expected none", d, res_idx[d], res_data[d]);
          end else begin
            check($sformatf("res_idx%0d", d), 64'(res_idx[d]), 64'(e.idx));
            check($sformatf("res_data%0d", d), 64'(res_data[d]), 64'(e.data));
            pend[d] = (e.idx == 2'd3);
          end
        end
      end
    end
    if (!rst_n) begin q0.delete(); q1.delete(); end
  end

  task automatic load8(input int d, input vec_t v, input bit poke_start);
    int n = 0;
    int t = 0;
    while (n < 8 && t < 200) begin
      check("no_feed_in_load", {62'd0, mmu_clear[d], feed_en[d]}, 64'd0);
      if (load_ready[d] && (n == 0 || $urandom_range(0, 3) != 0)) begin
        load_valid[d] = 1'b1;
        load_data[d]  = v.b[n];
        n++;
      end else begin
        load_valid[d] = 1'b0;
        load_data[d]  = 8'h5A;
      end
      start[d] = poke_start && (n == 3);
      @(negedge clk);
      t++;
    end
    load_valid[d] = 1'b0;
    start[d] = 1'b0;
    check("load_in_time", 64'(t < 200), 64'd1);
  endtask

  task automatic start_run(input int d, input vec_t v, input bit hold_lv, input bit stall);
    int  first = (d == 0) ? 8 : 6;
    int  t;
    bit  seen = 1'b0;
    for (int k = 0; k < 4; k++) push(d, 2'(k), v.c[k]);
    check("armed_ready", {62'd0, load_ready[d], busy[d]}, 64'd0);
    check("armed_operands", {inputs[d], weights[d]}, v.b);
    if (hold_lv) begin
      load_valid[d] = 1'b1;
      load_data[d]  = 8'hEE;
      @(negedge clk);
      check("armed_drop", 64'(load_ready[d]), 64'd0);
    end
    start[d] = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      start[d] = 1'b0;
      if (k == 3) load_valid[d] = 1'b0;
      check($sformatf("clear_c%0d", k), 64'(mmu_clear[d]), 64'(k == 1));
      check($sformatf("feed_en_c%0d", k), 64'(feed_en[d]), 64'(k >= 2 && k <= 4));
      check($sformatf("feed_cyc_c%0d", k), 64'(feed_cycle[d]), (k >= 2 && k <= 4) ? 64'(k - 2) : 64'd0);
      check($sformatf("res_valid_c%0d", k), 64'(res_valid[d]), 64'(k >= first));
      check($sformatf("busy_c%0d", k), 64'(busy[d]), 64'd1);
    end
    if (stall) begin
      t = 0;
      while (!(res_valid[d] && res_idx[d] == 2'd1) && t < 20) begin @(negedge clk); t++; end
      check("stall_reach", 64'(t < 20), 64'd1);
      res_ready[d] = 1'b0;
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        check("stall_hold", {res_valid[d], res_idx[d], res_data[d], done[d]}, {1'b1, 2'd1, v.c[1], 1'b0});
      end
      res_ready[d] = 1'b1;
    end
    t = 0;
    while (!seen && t < 60) begin
      @(negedge clk);
      t++;
      seen = done[d];
    end
    check("done_seen", 64'(seen), 64'd1);
    check("operands_kept", {inputs[d], weights[d]}, v.b);
    check("queue_drained", 64'((d == 0) ? q0.size() : q1.size()), 64'd0);
  endtask

  initial begin
    tbl[0].b = {8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    tbl[0].c = {16'd46, 16'd34, 16'd31, 16'd23};
    tbl[1].b = {8{8'hFF}};
    tbl[1].c = {4{16'd64514}};
    tbl[2].b = {8'd9, 8'd9, 8'd9, 8'd9, 8'd0, 8'd0, 8'd0, 8'd0};
    tbl[2].c = {4{16'd0}};
    tbl[3].b = {8'd4, 8'd3, 8'd2, 8'd1, 8'd40, 8'd30, 8'd20, 8'd10};
    tbl[3].c = {16'd220, 16'd100, 16'd150, 16'd70};
    tbl[4].b = {8'd5, 8'd13, 8'd11, 8'd7, 8'd3, 8'd0, 8'd0, 8'd2};
    tbl[4].c = {16'd15, 16'd33, 16'd26, 16'd14};
    for (int d = 0; d < 2; d++) begin
      load_valid[d] = 1'b0;
      load_data[d]  = '0;
      start[d]      = 1'b0;
      res_ready[d]  = 1'b1;
    end

    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("reset_ctrl", {res_data[d], load_ready[d], busy[d], done[d], feed_en[d], feed_cycle[d],
                           mmu_clear[d], res_valid[d], res_idx[d]}, 64'd0);
      check("reset_operands", {inputs[d], weights[d]}, 64'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_ready", 64'(load_ready[0]), 64'd1);

    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    check("idle_start_ignored", {60'd0, mmu_clear[0], feed_en[0], busy[0], load_ready[0]}, 64'd1);

    for (int i = 0; i < 5; i++) begin
      if (i > 0) check("b2b_done_ready", {62'd0, done[0], load_ready[0]}, 64'd3);
      load8(0, tbl[i], i == 2);
      start_run(0, tbl[i], i == 4, i == 1);
    end

    load8(0, tbl[3], 1'b0);
    start[0] = 1'b1;
    repeat (3) begin @(negedge clk); start[0] = 1'b0; end
    check("pre_abort_feed", {61'd0, feed_en[0], feed_cycle[0]}, 64'd5);
    #3 rst_n = 1'b0;
    #1;
    check("abort_ctrl", {res_data[0], load_ready[0], busy[0], done[0], feed_en[0], feed_cycle[0],
                         mmu_clear[0], res_valid[0], res_idx[0]}, 64'd0);
    check("abort_operands", {inputs[0], weights[0]}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_idle", {62'd0, load_ready[0], busy[0]}, 64'd2);
    load8(0, tbl[0], 1'b0);
    start_run(0, tbl[0], 1'b0, 1'b0);

    for (int i = 0; i < 2; i++) begin
      load8(1, tbl[i], 1'b0);
      start_run(1, tbl[i], 1'b0, 1'b0);
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", checks, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
